// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC register, issues fetch requests to
// instruction memory, and fills the IF/ID pipeline register. Redirects from
// decode (ID_HazardControl) override stalls and discard any returning data.
// A sticky fetch_err flags a memory that stays not-ready for MAX_WAIT
// consecutive request cycles; fetching carries on regardless.
//
// Handshake: a fetch is accepted on a rising edge where imem_req=1 and
// imem_ready=1 and no redirect is present; imem_ready is ignored whenever
// imem_req=0, and imem_req depends only on state and stall (never on ready).
module if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] newPC,
  input  logic        ID_HazardControl,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] currentPC,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  output logic [15:0] IF_PC,
  output logic [15:0] IF_instr,
  output logic        IF_valid,
  output logic        fetch_err,
  output logic [1:0]  dbg_state
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [15:0]   pc;
  logic [WW-1:0] wait_cnt;
  logic          redirect;
  logic          accept;
  logic          waiting;

  assign imem_req  = (state == S_FETCH) && !stall;
  assign imem_addr = pc;
  assign currentPC = pc + 16'd1;
  assign dbg_state = state;

  // A redirect is honoured in every state except the single boot cycle.
  assign redirect = ID_HazardControl && (state != S_BOOT);
  assign accept   = imem_req && imem_ready && !ID_HazardControl;
  assign waiting  = imem_req && !imem_ready && !ID_HazardControl;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_next;
  end

  // Next-state logic: state tracks stall only; redirects never change state.
  always_comb begin
    state_next = state;
    case (state)
      S_BOOT:  state_next = S_FETCH;
      S_FETCH: if (stall)  state_next = S_STALL;
      S_STALL: if (!stall) state_next = S_FETCH;
      default: state_next = S_BOOT;
    endcase
  end

  // PC and IF/ID register: redirect beats accept beats bubble; stall holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      IF_PC    <= 16'h0000;
      IF_instr <= 16'h0000;
      IF_valid <= 1'b0;
    end else if (redirect) begin
      pc       <= newPC;
      IF_valid <= 1'b0;
    end else if (accept) begin
      pc       <= newPC;
      IF_PC    <= pc;
      IF_instr <= imem_data;
      IF_valid <= 1'b1;
    end else if (imem_req) begin
      IF_valid <= 1'b0;
    end
  end

  // Consecutive not-ready request cycles; anything else restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (waiting) begin
      if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky timeout flag, set on the edge that completes the MAX_WAIT-th wait.
  always_ff @(posedge clk) begin
    if (!rst_n)                                     fetch_err <= 1'b0;
    else if (waiting && wait_cnt == WW'(MAX_WAIT - 1)) fetch_err <= 1'b1;
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: scenario tasks drive the fetch stage cycle by cycle;
// accepted fetches push {pc, instr} onto exp_q and are popped when the
// IF/ID register is expected to show them.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic [15:0] new_pc;
  logic        id_hc;
  logic        stall;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic [15:0] current_pc;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] if_pc;
  logic [15:0] if_instr;
  logic        if_valid;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  logic        tie;
  logic [15:0] np_drv;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  int          checks = 0;
  int          errors = 0;

  localparam logic [15:0] KEY = 16'hA5A5;

  // newPC either follows currentPC (sequential fetch) or a driven value.
  assign new_pc    = tie ? current_pc : np_drv;
  assign imem_data = imem_addr ^ KEY;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .newPC(new_pc), .ID_HazardControl(id_hc),
    .stall(stall), .imem_ready(imem_ready), .imem_data(imem_data),
    .currentPC(current_pc), .imem_addr(imem_addr), .imem_req(imem_req),
    .IF_PC(if_pc), .IF_instr(if_instr), .IF_valid(if_valid),
    .fetch_err(fetch_err), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic r, input logic h, input logic [15:0] np,
                       input logic t, input logic s, input logic rdy);
    rst_n = r; id_hc = h; np_drv = np; tie = t; stall = s; imem_ready = rdy;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [15:0] a);
    exp_q.push_back({a, a ^ KEY});
  endtask

  task automatic test_reset;
    drive(0, 0, 16'h0, 0, 0, 1);
    tick; tick;
    checks++; if (if_pc !== 16'h0) begin errors++; $display("FAIL rst_if_pc got %h exp 0000", if_pc); end
    checks++; if (if_instr !== 16'h0) begin errors++; $display("FAIL rst_if_instr got %h exp 0000", if_instr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got %b exp 0", if_valid); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_fetch_err got %b exp 0", fetch_err); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 16'h0) begin errors++; $display("FAIL rst_imem_addr got %h exp 0000", imem_addr); end
    checks++; if (current_pc !== 16'h1) begin errors++; $display("FAIL rst_current_pc got %h exp 0001", current_pc); end
    // First cycle after release is boot: no request, ready ignored.
    drive(1, 0, 16'h0, 1, 0, 1);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_imem_req got %b exp 0", imem_req); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL boot_state got %0d exp 0", dbg_state); end
    tick;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL boot_ready_ignored got %b exp 0", if_valid); end
    checks++; if (imem_addr !== 16'h0) begin errors++; $display("FAIL first_addr got %h exp 0000", imem_addr); end
  endtask

  task automatic test_stream;
    drive(1, 0, 16'h0, 1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_req got %b exp 1", imem_req); end
      checks++; if (imem_addr !== 16'(k)) begin errors++; $display("FAIL stream_addr got %h exp %h", imem_addr, 16'(k)); end
      push_fetch(16'(k));
      tick;
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL stream_pop got empty exp entry"); end
      else begin
        exp_v = exp_q.pop_front();
        if (if_valid !== 1'b1 || {if_pc, if_instr} !== exp_v) begin
          errors++; $display("FAIL stream_ifid got %b %h %h exp 1 %h", if_valid, if_pc, if_instr, exp_v);
        end
      end
    end
  endtask

  task automatic test_redirect;
    // pc=5: redirect and ready together; the returning data is discarded.
    drive(1, 1, 16'd1500, 0, 0, 1);
    checks++; if (imem_addr !== 16'd5) begin errors++; $display("FAIL redir_pre_addr got %h exp 0005", imem_addr); end
    tick;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", if_valid); end
    checks++; if (imem_addr !== 16'd1500) begin errors++; $display("FAIL redir_addr got %h exp %h", imem_addr, 16'd1500); end
    checks++; if (current_pc !== 16'd1501) begin errors++; $display("FAIL redir_cpc got %h exp %h", current_pc, 16'd1501); end
    drive(1, 0, 16'h0, 1, 0, 1);
    push_fetch(16'd1500);
    tick;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL redir_pop got empty exp entry"); end
    else begin
      exp_v = exp_q.pop_front();
      if (if_valid !== 1'b1 || {if_pc, if_instr} !== exp_v) begin
        errors++; $display("FAIL redir_ifid got %b %h %h exp 1 %h", if_valid, if_pc, if_instr, exp_v);
      end
    end
    // Move to pc=7 with IF_PC=6 holding a valid instruction.
    drive(1, 1, 16'd6, 0, 0, 0);
    tick;
    drive(1, 0, 16'h0, 1, 0, 1);
    push_fetch(16'd6);
    tick;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL redir6_pop got empty exp entry"); end
    else begin
      exp_v = exp_q.pop_front();
      if (if_valid !== 1'b1 || {if_pc, if_instr} !== exp_v) begin
        errors++; $display("FAIL redir6_ifid got %b %h %h exp 1 %h", if_valid, if_pc, if_instr, exp_v);
      end
    end
  endtask

  task automatic test_stall;
    drive(1, 0, 16'h0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got %b exp 0", imem_req); end
      tick;
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 16'd6 || if_instr !== (16'd6 ^ KEY) || imem_addr !== 16'd7) begin
        errors++; $display("FAIL stall_hold got %b %h %h %h exp 1 0006 %h 0007", if_valid, if_pc, if_instr, imem_addr, 16'd6 ^ KEY);
      end
      checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL stall_state got %0d exp 2", dbg_state); end
    end
    drive(1, 0, 16'h0, 1, 0, 1);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL unstall_req got %b exp 0", imem_req); end
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'd7) begin errors++; $display("FAIL resume got %b %h exp 1 0007", imem_req, imem_addr); end
    push_fetch(16'd7);
    tick;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL resume_pop got empty exp entry"); end
    else begin
      exp_v = exp_q.pop_front();
      if (if_valid !== 1'b1 || {if_pc, if_instr} !== exp_v) begin
        errors++; $display("FAIL resume_ifid got %b %h %h exp 1 %h", if_valid, if_pc, if_instr, exp_v);
      end
    end
    // Redirect while stalled: pc moves, state stays stalled.
    drive(1, 0, 16'h0, 1, 1, 1);
    tick;
    drive(1, 1, 16'h0100, 0, 1, 1);
    tick;
    checks++;
    if (imem_req !== 1'b0 || dbg_state !== 2'd2 || imem_addr !== 16'h0100 || if_valid !== 1'b0) begin
      errors++; $display("FAIL stall_redir got %b %0d %h %b exp 0 2 0100 0", imem_req, dbg_state, imem_addr, if_valid);
    end
    drive(1, 0, 16'h0, 1, 0, 1);
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errors++; $display("FAIL stall_redir_resume got %b %h exp 1 0100", imem_req, imem_addr); end
    push_fetch(16'h0100);
    tick;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL stall_redir_pop got empty exp entry"); end
    else begin
      exp_v = exp_q.pop_front();
      if (if_valid !== 1'b1 || {if_pc, if_instr} !== exp_v) begin
        errors++; $display("FAIL stall_redir_ifid got %b %h %h exp 1 %h", if_valid, if_pc, if_instr, exp_v);
      end
    end
  endtask

  task automatic test_wrap;
    drive(1, 1, 16'hFFFF, 0, 0, 0);
    tick;
    drive(1, 0, 16'h0, 1, 0, 1);
    checks++; if (current_pc !== 16'h0000) begin errors++; $display("FAIL wrap_cpc got %h exp 0000", current_pc); end
    checks++; if (imem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr got %h exp ffff", imem_addr); end
    push_fetch(16'hFFFF);
    tick;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_pop got empty exp entry"); end
    else begin
      exp_v = exp_q.pop_front();
      if (if_valid !== 1'b1 || {if_pc, if_instr} !== exp_v) begin
        errors++; $display("FAIL wrap_ifid got %b %h %h exp 1 %h", if_valid, if_pc, if_instr, exp_v);
      end
    end
    checks++; if (imem_addr !== 16'h0000 || current_pc !== 16'h0001) begin errors++; $display("FAIL wrap_after got %h %h exp 0000 0001", imem_addr, current_pc); end
  endtask

  task automatic test_timeout;
    // Five waits then an accept: the count restarts, so no error yet.
    drive(1, 0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick;
    drive(1, 0, 16'h0, 1, 0, 1);
    tick;
    drive(1, 0, 16'h0, 1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      tick;
      checks++;
      if (fetch_err !== (i == 8) || if_valid !== 1'b0 || imem_addr !== 16'h0001) begin
        errors++; $display("FAIL timeout_wait%0d got %b %b %h exp %b 0 0001", i, fetch_err, if_valid, imem_addr, (i == 8));
      end
    end
    drive(1, 0, 16'h0, 1, 0, 1);
    for (int k = 1; k < 3; k++) begin
      push_fetch(16'(k));
      tick;
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL timeout_pop got empty exp entry"); end
      else begin
        exp_v = exp_q.pop_front();
        if (if_valid !== 1'b1 || {if_pc, if_instr} !== exp_v) begin
          errors++; $display("FAIL timeout_ifid got %b %h %h exp 1 %h", if_valid, if_pc, if_instr, exp_v);
        end
      end
      checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", fetch_err); end
    end
  endtask

  task automatic test_reset_mid;
    drive(1, 0, 16'h0, 1, 0, 0);
    tick;
    drive(0, 1, 16'h1234, 0, 1, 0);
    tick;
    checks++;
    if (if_pc !== 16'h0 || if_instr !== 16'h0 || if_valid !== 1'b0 || fetch_err !== 1'b0) begin
      errors++; $display("FAIL midrst_regs got %h %h %b %b exp 0000 0000 0 0", if_pc, if_instr, if_valid, fetch_err);
    end
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0 || current_pc !== 16'h1 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL midrst_outs got %b %h %h %0d exp 0 0000 0001 0", imem_req, imem_addr, current_pc, dbg_state);
    end
    drive(1, 0, 16'h0, 1, 0, 1);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midrst_boot_req got %b exp 0", imem_req); end
    tick;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL midrst_fetch_req got %b exp 1", imem_req); end
    push_fetch(16'h0);
    tick;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL midrst_pop got empty exp entry"); end
    else begin
      exp_v = exp_q.pop_front();
      if (if_valid !== 1'b1 || {if_pc, if_instr} !== exp_v) begin
        errors++; $display("FAIL midrst_ifid got %b %h %h exp 1 %h", if_valid, if_pc, if_instr, exp_v);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; id_hc = 1'b0; np_drv = 16'h0; tie = 1'b0;
    stall = 1'b0; imem_ready = 1'b0;
    test_reset;
    test_stream;
    test_redirect;
    test_stall;
    test_wrap;
    test_timeout;
    test_reset_mid;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drain got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
